regset_sb: RTL
==============

Name: regset_sb

Overview:
- Parametrised next-generation register set for the RO2 core datapath, sitting between decode (issue) and writeback.
- Width, depth and read-port count are configurable.
- An optional write-to-read bypass gives same-cycle forwarding.
- A per-register busy scoreboard flags RAW and WAW hazards to the stall logic.
- Register 0 stays hardwired to zero and is never busy.

Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W registers
- N_RD, 2, number of asynchronous read ports (1..4)
- BYPASS, 1, 1 = writeback data is forwarded combinationally to matching read ports; 0 = no forwarding

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RES  in  1  synchronous, active-high reset
- D  in  DATA_W  writeback data
- A_D  in  ADDR_W  writeback address
- write_enable  in  1  writeback strobe
- A_Q  in  N_RD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- Q  out  N_RD*DATA_W  read data; port i is bits [i*DATA_W +: DATA_W]
- RD_BUSY  out  N_RD  1 = register on read port i awaits a writeback (RAW hazard)
- issue_en  in  1  an instruction issues with destination A_ISSUE
- A_ISSUE  in  ADDR_W  destination register of the issuing instruction
- issue_conflict  out  1  issue_en=1 and A_ISSUE is already busy (WAW hazard); combinational

Behaviour:
- Reset (RES=1 at a rising edge):
  - All 2**ADDR_W data registers become 0; all busy bits become 0.
  - write_enable and issue_en are ignored in that cycle.
  - From the next cycle: every Q = 0, RD_BUSY = 0, issue_conflict = 0.
- Reset mid-operation: pending busy bits are dropped. A writeback arriving in the same cycle as RES is lost.
- Write: on a rising edge with RES=0, write_enable=1 and A_D != 0, dat[A_D] <= D and busy[A_D] <= 0. Writes to address 0 are discarded.
- Issue: on a rising edge with RES=0, issue_en=1 and A_ISSUE != 0, busy[A_ISSUE] <= 1.
  - issue_conflict is advisory only; the busy bit is set regardless.
  - issue_en with A_ISSUE = 0 has no effect, and issue_conflict = 0.
- Issue and writeback to the same register in the same cycle: data is written and busy ends at 1 (the new producer wins).
- Read (combinational, zero latency):
  - Q[i] = dat[A_Q[i]] and RD_BUSY[i] = busy[A_Q[i]].
  - Address 0 always yields Q = 0 and RD_BUSY = 0.
- Bypass (BYPASS=1 only): when RES=0, write_enable=1, A_D != 0 and A_D == A_Q[i], port i gets Q[i] = D and RD_BUSY[i] = 0 in the same cycle.
  - Applies independently to every matching port.
  - Bypass is suppressed while RES=1.
- BYPASS=0: the written value appears on Q from the cycle after the edge; RD_BUSY clears at the same time.
- Multiple read ports may read the same address simultaneously; there are no port conflicts.
- Widths: all addresses are unsigned. There are no out-of-range addresses, since depth = 2**ADDR_W.

Decomposition:
- Shared package regset_pkg holds:
  - default constants REGSET_DATA_W=32, REGSET_ADDR_W=5;
  - localparam ZERO_REG=0;
  - a slice-helper function for flattened port vectors.
- One sub-module, regset_scoreboard:
  - busy-bit array with set/clear priority and reset;
  - outputs the busy vector and issue_conflict;
  - the top level instantiates it and does data storage, read muxing and bypass.

Test Plan:
- Reset: write 0xDEADBEEF to r5, pulse RES for one cycle -> next cycle Q(A_Q=5)=0, RD_BUSY=0.
- Write/read with x0 guard: write 0x12345678 to r7 and 0xFFFFFFFF to r0 -> port0(A_Q=7)=0x12345678, port1(A_Q=0)=0.
- Bypass (BYPASS=1): A_Q0=A_Q1=9, write_enable=1, A_D=9, D=0xA5A5A5A5 -> both ports show 0xA5A5A5A5 in the same cycle. With BYPASS=0 the ports show the old value, then the new value one cycle later.
- Scoreboard RAW:
  - issue r3, then read r3 -> RD_BUSY=1;
  - write r3 with 0x55 -> RD_BUSY=0 that cycle (bypass on) and Q=0x55.
- WAW and simultaneous events:
  - issue r4 twice -> issue_conflict=1 on the second issue;
  - issue r4 and write r4=0x77 in the same cycle -> next cycle Q=0x77 and RD_BUSY=1.
- Reset mid-operation: busy r2 and r6, assert RES together with a write to r2 -> next cycle all RD_BUSY=0 and Q(r2)=0.

Source files
------------

// File: rtl/regset_pkg.sv
// Shared definitions for the regset_sb register set.
//   REGSET_DATA_W / REGSET_ADDR_W : default word and address widths
//   ZERO_REG                      : hardwired-zero register index
//   slice_lsb()                   : LSB position of element idx in a flattened vector
package regset_pkg;

  localparam int REGSET_DATA_W = 32;
  localparam int REGSET_ADDR_W = 5;
  localparam int ZERO_REG      = 0;

  function automatic int slice_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regset_scoreboard.sv
// Per-register busy scoreboard.
//   clk, res       : clock, synchronous active-high reset
//   wr_en, a_wr    : writeback strobe/address (clears busy)
//   issue_en,a_iss : issue strobe/destination (sets busy)
//   busy           : busy vector, one bit per register (bit 0 always 0)
//   issue_conflict : issuing onto an already-busy register (WAW)
module regset_scoreboard
  import regset_pkg::*;
#(
  parameter int ADDR_W = REGSET_ADDR_W
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      a_wr,
  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      a_iss,
  output logic [2**ADDR_W-1:0]   busy,
  output logic                   issue_conflict
);

  logic wr_ok, iss_ok;

  assign wr_ok  = wr_en    && (a_wr  != ADDR_W'(ZERO_REG));
  assign iss_ok = issue_en && (a_iss != ADDR_W'(ZERO_REG));

  // Set is applied after clear so a same-cycle issue to the register
  // being written back leaves it busy: the new producer wins.
  always_ff @(posedge clk) begin
    if (res) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[a_wr]  <= 1'b0;
      if (iss_ok) busy[a_iss] <= 1'b1;
    end
  end

  assign issue_conflict = iss_ok && busy[a_iss];

endmodule

// File: rtl/regset_sb.sv
// Parametrised register set with optional write-to-read bypass and a
// busy scoreboard for RAW/WAW hazard detection. Register 0 reads as zero.
//   CLK, RES             : clock, synchronous active-high reset
//   D, A_D, write_enable : writeback port
//   A_Q, Q, RD_BUSY      : N_RD flattened asynchronous read ports
//   issue_en, A_ISSUE    : issue port (marks destination busy)
//   issue_conflict       : WAW hazard flag, combinational
module regset_sb
  import regset_pkg::*;
#(
  parameter int DATA_W = REGSET_DATA_W,
  parameter int ADDR_W = REGSET_ADDR_W,
  parameter int N_RD   = 2,
  parameter int BYPASS = 1
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic [DATA_W-1:0]        D,
  input  logic [ADDR_W-1:0]        A_D,
  input  logic                     write_enable,
  input  logic [N_RD*ADDR_W-1:0]   A_Q,
  output logic [N_RD*DATA_W-1:0]   Q,
  output logic [N_RD-1:0]          RD_BUSY,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        A_ISSUE,
  output logic                     issue_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] dat;
  logic [DEPTH-1:0]             busy;
  logic                         wr_ok;

  assign wr_ok = write_enable && (A_D != ADDR_W'(ZERO_REG));

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge CLK) begin
    if (RES) begin
      dat <= '0;
    end else if (wr_ok) begin
      dat[A_D] <= D;
    end
  end

  regset_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk            (CLK),
    .res            (RES),
    .wr_en          (write_enable),
    .a_wr           (A_D),
    .issue_en       (issue_en),
    .a_iss          (A_ISSUE),
    .busy           (busy),
    .issue_conflict (issue_conflict)
  );

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;

    assign addr = A_Q[slice_lsb(i, ADDR_W) +: ADDR_W];
    // wr_ok already excludes register 0; reset suppresses forwarding.
    assign hit  = (BYPASS != 0) && !RES && wr_ok && (A_D == addr);

    assign Q[slice_lsb(i, DATA_W) +: DATA_W] = hit ? D : dat[addr];
    assign RD_BUSY[i] = hit ? 1'b0 : busy[addr];
  end

endmodule
